scan_sequencer: RTL and testbench
=================================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL provide parameter DWELL_CYCLES, default 8, number of clock cycles each enabled channel is held selected (legal range 1..255).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  single-scan request, accepted only when busy=0.
REQ-006 SHALL have port continuous  input  1  when 1, rescan immediately after each completed frame.
REQ-007 SHALL have port chan_mask  input  16  channel enables, sampled at scan start.
REQ-008 SHALL have port sense  input  1  return line of the currently selected channel.
REQ-009 SHALL have port sel  output  4  channel index driven to the downstream 4-to-16 one-hot decoder.
REQ-010 SHALL have port sel_valid  output  1  high while sel addresses a channel being dwelt on.
REQ-011 SHALL have port frame  output  16  completed scan result, bit i = sense sampled on channel i.
REQ-012 SHALL have port frame_valid  output  1  frame holds an unconsumed result.
REQ-013 SHALL have port frame_ready  input  1  consumer accepts frame.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port overrun  output  1  sticky: an unconsumed frame was overwritten.

Function
REQ-016 SHALL implement states IDLE and SCAN; busy = (state==SCAN).
REQ-017 IDLE: sel=0, sel_valid=0; start=1 latches chan_mask into a scan mask, clears overrun, clears the shadow frame, and enters SCAN.
REQ-018 On scan entry with nonzero mask, sel SHALL be the lowest set mask bit and sel_valid=1 from the next cycle.
REQ-019 On scan entry with mask==0, SHALL not enter SCAN; frame<=0 and frame_valid<=1 at the same edge.
REQ-020 SCAN: an 8-bit dwell counter counts 0..DWELL_CYCLES-1; at the edge where count==DWELL_CYCLES-1, sense SHALL be written to shadow bit sel.
REQ-021 At that edge, sel SHALL advance directly to the next higher set mask bit (no gap cycle); disabled channels are never selected and read 0 in frame.
REQ-022 When no higher set bit exists, the same edge SHALL load frame with the completed shadow (including the final sample) and set frame_valid=1.
REQ-023 Latency: with N enabled channels, frame_valid SHALL rise exactly N*DWELL_CYCLES cycles after the first sel_valid=1 cycle.
REQ-024 At scan completion with continuous=1, SHALL resample chan_mask, clear shadow and start the next scan with sel_valid continuously high; with continuous=0, SHALL return to IDLE.
REQ-025 continuous deasserted mid-scan SHALL let the current scan finish, then go IDLE.
REQ-026 Handshake: transfer occurs on an edge with frame_valid=1 and frame_ready=1; frame_valid then clears unless a new frame loads at the same edge, in which case it stays 1 with the new frame.
REQ-027 frame and frame_valid SHALL hold stable while frame_valid=1 and frame_ready=0, except when overwritten by a newer frame.
REQ-028 Loading a new frame while frame_valid=1 and frame_ready=0 SHALL set overrun=1; overrun is cleared only by an accepted start or reset.
REQ-029 start while busy=1 SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, sel=0, sel_valid=0, frame=0, frame_valid=0, busy=0, overrun=0, dwell count=0, shadow=0, regardless of clock.
REQ-031 After rst_n rises, SHALL remain IDLE until start=1, even if continuous=1.

Verification
REQ-032 DWELL=4, mask=FFFF, sense=1 only when sel==5 or 10, single start -> sel steps 0..15 at 4 cycles each, frame=0x0420, frame_valid 64 cycles after first sel_valid, held until frame_ready.
REQ-033 DWELL=4, mask=8001 -> sel=0 for 4 cycles then 15 for 4 cycles; frame_valid after 8 cycles; bits 1..14 zero even with sense tied 1 (frame=0x8001).
REQ-034 mask=0000, start -> no sel_valid, frame=0, frame_valid=1 next cycle, busy stays 0.
REQ-035 continuous=1, frame_ready=0 for two complete scans -> second frame replaces first, overrun=1, sel_valid never drops between scans.
REQ-036 rst_n pulled low mid-dwell on channel 7 -> all outputs 0 without a clock edge; after release stays IDLE.
REQ-037 start pulsed while busy -> ignored; scan result and overrun unchanged.

Source files
------------

// File: rtl/scan_sequencer.sv
// Scans the enabled channels in ascending order and dwells DWELL_CYCLES on each channel.
// After the last channel it publishes the sensed bits as one 16-bit frame, using a valid/ready handshake.
module scan_sequencer #(
  parameter int DWELL_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        continuous,
  input  logic [15:0] chan_mask,
  input  logic        sense,
  output logic [3:0]  sel,
  output logic        sel_valid,
  output logic [15:0] frame,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [7:0] LAST = 8'(DWELL_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] mask;
  logic [15:0] shadow;
  logic [15:0] shadow_upd;
  logic [7:0]  dwell;
  logic [3:0]  first_sel;
  logic [3:0]  next_sel;
  logic        has_next;
  logic        accept;
  logic        zero_start;
  logic        dwell_end;
  logic        scan_done;
  logic        rescan;
  logic        load;
  logic [15:0] load_dat;

  always_comb begin
    first_sel = '0;
    for (int i = 15; i >= 0; i--)
      if (chan_mask[i]) first_sel = 4'(i);
  end

  always_comb begin
    next_sel = '0;
    has_next = 1'b0;
    for (int i = 15; i >= 0; i--)
      if (mask[i] && (i > int'(sel))) begin
        next_sel = 4'(i);
        has_next = 1'b1;
      end
  end

  // Shadow including the sample taken at the current edge, so the final channel lands in the frame.
  always_comb begin
    shadow_upd      = shadow;
    shadow_upd[sel] = sense;
  end

  assign accept     = (state == IDLE) && start;
  assign zero_start = accept && (chan_mask == '0);
  assign dwell_end  = (state == SCAN) && (dwell == LAST);
  assign scan_done  = dwell_end && !has_next;
  assign rescan     = scan_done && continuous && (chan_mask != '0);
  assign load       = zero_start || scan_done;
  assign load_dat   = zero_start ? '0 : shadow_upd;

  assign busy      = (state == SCAN);
  assign sel_valid = (state == SCAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (chan_mask != '0)) state_nxt = SCAN;
      SCAN:    if (scan_done && !rescan) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask   <= '0;
      shadow <= '0;
      sel    <= '0;
      dwell  <= '0;
    end else if (accept) begin
      mask   <= chan_mask;
      shadow <= '0;
      sel    <= first_sel;
      dwell  <= '0;
    end else if (dwell_end) begin
      dwell <= '0;
      if (has_next) begin
        sel    <= next_sel;
        shadow <= shadow_upd;
      end else if (rescan) begin
        mask   <= chan_mask;
        shadow <= '0;
        sel    <= first_sel;
      end else begin
        shadow <= shadow_upd;
        sel    <= '0;
      end
    end else if (state == SCAN) begin
      dwell <= dwell + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame       <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (load) begin
        frame       <= load_dat;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
      // A start clears stale overrun, but an empty-mask start can itself overwrite a pending frame.
      if (accept)
        overrun <= load && frame_valid && !frame_ready;
      else if (load && frame_valid && !frame_ready)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Randomized and directed bench for scan_sequencer.
// A channel-queue reference model predicts every output on every cycle.
module tb_scan_sequencer;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [15:0] chan_mask = '0;
  logic        sense = 1'b0;
  logic [3:0]  sel;
  logic        sel_valid;
  logic [15:0] frame;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic        busy;
  logic        overrun;

  scan_sequencer #(.DWELL_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .chan_mask(chan_mask), .sense(sense), .sel(sel), .sel_valid(sel_valid),
    .frame(frame), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of channels still to visit plus the remaining dwell on the current one.
  bit          m_busy;
  int          m_cur;
  int          m_left;
  int          m_chans[$];
  bit [15:0]   m_shadow;
  bit [15:0]   m_frame;
  bit          m_fv;
  bit          m_ovr;
  bit          use_pat;
  logic [15:0] pat;

  function automatic void m_reset();
    m_busy = 0; m_cur = 0; m_left = 0; m_chans.delete();
    m_shadow = '0; m_frame = '0; m_fv = 0; m_ovr = 0;
  endfunction

  function automatic void m_begin(input logic [15:0] msk);
    m_chans.delete();
    for (int i = 0; i < 16; i++) if (msk[i]) m_chans.push_back(i);
    m_cur = m_chans.pop_front();
    m_left = D;
    m_busy = 1;
    m_shadow = '0;
  endfunction

  function automatic int m_sel();
    return m_busy ? m_cur : 0;
  endfunction

  function automatic void m_step();
    bit        ld = 0;
    bit [15:0] nf = '0;
    if (!m_busy) begin
      if (start) begin
        m_ovr = 0;
        m_shadow = '0;
        if (chan_mask == '0) ld = 1;
        else m_begin(chan_mask);
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_shadow[m_cur] = sense;
        if (m_chans.size() > 0) begin
          m_cur = m_chans.pop_front();
          m_left = D;
        end else begin
          ld = 1;
          nf = m_shadow;
          m_busy = 0;
          if (continuous && chan_mask != '0) m_begin(chan_mask);
        end
      end
    end
    if (ld) begin
      if (m_fv && !frame_ready) m_ovr = 1;
      m_frame = nf;
      m_fv = 1;
    end else if (m_fv && frame_ready) begin
      m_fv = 0;
    end
  endfunction

  task automatic compare_all();
    chk("sel", 32'(sel), 32'(m_sel()));
    chk("sel_valid", 32'(sel_valid), 32'(m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame", 32'(frame), 32'(m_frame));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  // One clock: inputs are set at the falling edge, the model advances at the rising edge.
  task automatic step();
    if (use_pat) sense = pat[m_sel()];
    @(posedge clk);
    m_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_to_frame(input string tag, input int exp_lat, input logic [15:0] exp_frame);
    int n = 0;
    while (!frame_valid && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_frame"}, 32'(frame), 32'(exp_frame));
  endtask

  initial begin
    m_reset();
    use_pat = 0;
    pat = '0;
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    continuous = 1'b1;
    repeat (3) step();

    // Full mask, only channels 5 and 10 sense high.
    continuous = 1'b0;
    use_pat = 1; pat = 16'h0420; chan_mask = 16'hFFFF;
    start = 1'b1; step(); start = 1'b0;
    chk("a_first_sel_valid", 32'(sel_valid), 32'd1);
    run_to_frame("a", 64, 16'h0420);
    repeat (3) step();
    chk("a_hold", 32'(frame_valid), 32'd1);
    frame_ready = 1'b1; step(); frame_ready = 1'b0;

    // Only the end channels are enabled; sense is tied high.
    pat = 16'hFFFF; chan_mask = 16'h8001;
    start = 1'b1; step(); start = 1'b0;
    run_to_frame("b", 8, 16'h8001);
    frame_ready = 1'b1; step(); frame_ready = 1'b0;

    // Empty mask publishes a zero frame without scanning.
    chan_mask = 16'h0000;
    start = 1'b1; step(); start = 1'b0;
    chk("c_busy", 32'(busy), 32'd0);
    chk("c_fv", 32'(frame_valid), 32'd1);
    frame_ready = 1'b1; step(); frame_ready = 1'b0;

    // Continuous scans with the consumer stalled.
    pat = 16'h0050; chan_mask = 16'h00F0; continuous = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 2 * 4 * D; i++) begin
      chk("d_sel_valid", 32'(sel_valid), 32'd1);
      step();
    end
    chk("d_overrun", 32'(overrun), 32'd1);
    continuous = 1'b0;
    for (int i = 0; i < 100 && busy; i++) step();
    frame_ready = 1'b1; step(); frame_ready = 1'b0;

    // Asynchronous reset in the middle of dwelling on channel 7.
    chan_mask = 16'hFFFF;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 200 && !(m_busy && m_cur == 7 && m_left == 2); i++) step();
    chk("e_on_ch7", 32'(sel), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1; continuous = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("e_idle", 32'(busy), 32'd0);
    continuous = 1'b0;

    // A start pulsed while busy is ignored.
    pat = 16'h0303; chan_mask = 16'h0F0F;
    start = 1'b1; step(); start = 1'b0;
    repeat (5) step();
    chan_mask = 16'hFFFF; start = 1'b1; step(); start = 1'b0;
    run_to_frame("f", 8 * D - 6, 16'h0303);
    frame_ready = 1'b1; step(); frame_ready = 1'b0;

    // Random traffic.
    use_pat = 0;
    for (int i = 0; i < 3000; i++) begin
      start       = ($urandom_range(0, 7) == 0);
      continuous  = ($urandom_range(0, 3) == 0);
      frame_ready = ($urandom_range(0, 2) == 0);
      sense       = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       chan_mask = 16'h0000;
        1:       chan_mask = 16'(1 << $urandom_range(0, 15));
        default: chan_mask = 16'($urandom);
      endcase
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
